ime_full_search: RTL

Integer-pel full-search motion estimator that sits directly upstream of `fme`. It captures one 4x4 current block, reads the 8x8 reference search window through a 1-cycle-latency read port, and computes the SAD at every integer candidate in ±2 pel. It returns the best integer motion vector and its SAD, which `fme` uses as the centre for its half- and quarter-pel refinement.

---
 rtl/ime_pkg.sv | 24 ++
 rtl/ime_sad_acc.sv | 43 ++++
 rtl/ime_full_search.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ime_pkg.sv
// ime_pkg: shared parameters, derived-width helpers and the FSM state type
// for the integer-pel full-search motion estimator.
//   BLK_DEF / RANGE_DEF / PIX_W_DEF / MV_W_DEF : default block side, search
//   range, pixel width and MV component width.
//   win_f   : search-window side for a block size and range.
//   sad_w_f : accumulator width able to hold a worst-case block SAD.
package ime_pkg;

  localparam int BLK_DEF   = 4;
  localparam int RANGE_DEF = 2;
  localparam int PIX_W_DEF = 8;
  localparam int MV_W_DEF  = 4;

  function automatic int win_f(input int blk, input int rng);
    return blk + 2 * rng;
  endfunction

  function automatic int sad_w_f(input int blk, input int pix_w);
    return $clog2(blk * blk * (2 ** pix_w - 1) + 1);
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DRAIN, DONE} ime_state_t;

endpackage

// File: rtl/ime_sad_acc.sv
// ime_sad_acc: per-candidate sum of absolute differences.
//   clk, rst   : clock, asynchronous active-low reset
//   in_valid   : a current/reference pixel pair is present this cycle
//   cur_pix    : registered current-block pixel
//   ref_pix    : reference pixel returned by the window read port
//   first      : pair is pixel (0,0) of a candidate; accumulation restarts
//   last       : pair is the final pixel of a candidate
//   sad        : running sum including this cycle's pair
//   sad_valid  : sad holds a complete candidate SAD
module ime_sad_acc #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  input  logic             first,
  input  logic             last,
  output logic [SAD_W-1:0] sad,
  output logic             sad_valid
);

  logic [SAD_W-1:0] acc_reg;
  logic [PIX_W-1:0] abs_diff;

  assign abs_diff = (cur_pix >= ref_pix) ? (cur_pix - ref_pix) : (ref_pix - cur_pix);

  // The sum is presented combinationally so the final pixel's contribution
  // can be compared in the same cycle it arrives.
  assign sad       = (first ? '0 : acc_reg) + SAD_W'(abs_diff);
  assign sad_valid = in_valid && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (in_valid) begin
      acc_reg <= sad;
    end
  end

endmodule

// File: rtl/ime_full_search.sv
// ime_full_search: integer-pel full-search motion estimator.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a search (accepted in IDLE only)
//   cur_valid/cur_pix   : current-block pixel beats, raster order
//   cur_ready           : high while loading the current block
//   ref_rd_en/ref_x/ref_y : window read request (data returns next cycle)
//   ref_pix             : window pixel for the previous cycle's request
//   busy                : any state other than IDLE
//   done                : one-cycle result strobe
//   best_mvx/best_mvy/best_sad : best integer MV and its SAD
module ime_full_search
  import ime_pkg::*;
#(
  parameter  int BLK   = BLK_DEF,
  parameter  int RANGE = RANGE_DEF,
  parameter  int PIX_W = PIX_W_DEF,
  parameter  int MV_W  = MV_W_DEF,
  localparam int WIN   = win_f(BLK, RANGE),
  localparam int SAD_W = sad_w_f(BLK, PIX_W),
  localparam int AW    = $clog2(WIN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cur_valid,
  input  logic [PIX_W-1:0]        cur_pix,
  output logic                    cur_ready,
  output logic                    ref_rd_en,
  output logic [AW-1:0]           ref_x,
  output logic [AW-1:0]           ref_y,
  input  logic [PIX_W-1:0]        ref_pix,
  output logic                    busy,
  output logic                    done,
  output logic signed [MV_W-1:0]  best_mvx,
  output logic signed [MV_W-1:0]  best_mvy,
  output logic [SAD_W-1:0]        best_sad
);

  localparam int NPIX = BLK * BLK;
  localparam int BW   = $clog2(NPIX);
  localparam int PW   = $clog2(BLK);
  localparam int CW   = $clog2(2 * RANGE + 1);

  ime_state_t state_reg, state_next;

  logic [BW-1:0] beat_reg;
  logic [PW-1:0] px_reg, py_reg;
  logic [CW-1:0] dxi_reg, dyi_reg;   // candidate offsets biased by +RANGE

  logic beat, beat_last, px_max, py_max, dx_max, dy_max, pix_last, scan_last;

  assign beat      = cur_valid && (state_reg == LOAD);
  assign beat_last = (beat_reg == BW'(NPIX - 1));
  assign px_max    = (px_reg == PW'(BLK - 1));
  assign py_max    = (py_reg == PW'(BLK - 1));
  assign dx_max    = (dxi_reg == CW'(2 * RANGE));
  assign dy_max    = (dyi_reg == CW'(2 * RANGE));
  assign pix_last  = px_max && py_max;
  assign scan_last = pix_last && dx_max && dy_max;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (beat && beat_last) state_next = SEARCH;
      SEARCH:  if (scan_last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cur_ready = (state_reg == LOAD);
  assign ref_rd_en = (state_reg == SEARCH);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign ref_x     = ref_rd_en ? (AW'(dxi_reg) + AW'(px_reg)) : '0;
  assign ref_y     = ref_rd_en ? (AW'(dyi_reg) + AW'(py_reg)) : '0;

  // ---------------- beat and scan counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_reg <= '0;
      px_reg   <= '0;
      py_reg   <= '0;
      dxi_reg  <= '0;
      dyi_reg  <= '0;
    end else begin
      if (state_reg == IDLE) beat_reg <= '0;
      else if (beat)         beat_reg <= beat_reg + 1'b1;

      // Scan counters sit at zero outside SEARCH so every search starts at
      // candidate (-RANGE,-RANGE), pixel (0,0).
      if (state_reg != SEARCH) begin
        px_reg  <= '0;
        py_reg  <= '0;
        dxi_reg <= '0;
        dyi_reg <= '0;
      end else begin
        px_reg <= px_max ? '0 : px_reg + 1'b1;
        if (px_max) begin
          py_reg <= py_max ? '0 : py_reg + 1'b1;
          if (py_max) begin
            dxi_reg <= dx_max ? '0 : dxi_reg + 1'b1;
            if (dx_max) dyi_reg <= dy_max ? '0 : dyi_reg + 1'b1;
          end
        end
      end
    end
  end

  // ---------------- current buffer (registered read) ----------------
  logic [PIX_W-1:0] cur_buf [NPIX];
  logic [PIX_W-1:0] cur_d_reg;
  logic [BW-1:0]    rd_idx;

  assign rd_idx = BW'(int'(py_reg) * BLK + int'(px_reg));

  always_ff @(posedge clk) begin
    if (beat) cur_buf[beat_reg] <= cur_pix;
    cur_d_reg <= cur_buf[rd_idx];
  end

  // ---------------- index delay line, aligned with ref_pix ----------------
  logic          vld_d_reg, first_d_reg, last_d_reg;
  logic [CW-1:0] dxi_d_reg, dyi_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_d_reg   <= 1'b0;
      first_d_reg <= 1'b0;
      last_d_reg  <= 1'b0;
      dxi_d_reg   <= '0;
      dyi_d_reg   <= '0;
    end else begin
      vld_d_reg   <= (state_reg == SEARCH);
      first_d_reg <= (px_reg == '0) && (py_reg == '0);
      last_d_reg  <= pix_last;
      dxi_d_reg   <= dxi_reg;
      dyi_d_reg   <= dyi_reg;
    end
  end

  logic [SAD_W-1:0] sad;
  logic             sad_valid;

  ime_sad_acc #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_sad_acc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_d_reg),
    .cur_pix   (cur_d_reg),
    .ref_pix   (ref_pix),
    .first     (first_d_reg),
    .last      (last_d_reg),
    .sad       (sad),
    .sad_valid (sad_valid)
  );

  // ---------------- min tracker ----------------
  logic [SAD_W-1:0]       min_sad_reg, min_sad_next;
  logic signed [MV_W-1:0] min_mvx_reg, min_mvx_next, min_mvy_reg, min_mvy_next;
  logic signed [MV_W-1:0] cand_mvx, cand_mvy;
  logic                   better;

  assign cand_mvx = MV_W'(dxi_d_reg) - MV_W'(RANGE);
  assign cand_mvy = MV_W'(dyi_d_reg) - MV_W'(RANGE);
  // Strict less-than keeps the earliest candidate on ties.
  assign better       = sad_valid && (sad < min_sad_reg);
  assign min_sad_next = better ? sad      : min_sad_reg;
  assign min_mvx_next = better ? cand_mvx : min_mvx_reg;
  assign min_mvy_next = better ? cand_mvy : min_mvy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_sad_reg <= '1;
      min_mvx_reg <= '0;
      min_mvy_reg <= '0;
      best_sad    <= '0;
      best_mvx    <= '0;
      best_mvy    <= '0;
    end else begin
      if (state_reg == LOAD) begin
        min_sad_reg <= '1;
        min_mvx_reg <= '0;
        min_mvy_reg <= '0;
      end else begin
        min_sad_reg <= min_sad_next;
        min_mvx_reg <= min_mvx_next;
        min_mvy_reg <= min_mvy_next;
      end
      // Published results change only here, so they are stable throughout
      // a search and valid during the done cycle.
      if (state_reg == DRAIN) begin
        best_sad <= min_sad_next;
        best_mvx <= min_mvx_next;
        best_mvy <= min_mvy_next;
      end
    end
  end

endmodule
